// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- instruction-memory bus between the fetch stage and the
// instruction memory.
//
// Signals:
//   imem_addr  : 64-bit fetch address, driven by the fetch stage.
//   imem_rdata : 32-bit instruction word at imem_addr, returned in the same
//                cycle (combinational read).
//
// Handshake: there is no valid/ready pair on this bus. The memory is a
// combinational read port, so every cycle is implicitly a valid request and
// the returned word is always accepted in the cycle it is presented.
//
// Modports:
//   master : fetch side (drives the address, samples the data)
//   slave  : memory side (samples the address, drives the data)
interface fetch_stage_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with PC register and IF/ID register.
//
// Parameters:
//   RESET_PC  : PC value loaded while arst is high.
//   NOP_INSTR : bubble instruction placed in IF/ID on flush or redirect.
//
// Ports:
//   clk, arst         : clock (rising edge) and async active-high reset
//   enable            : global core enable, low freezes every register
//   stall             : hazard-unit hold request
//   flush             : squash the IF/ID contents
//   branch_taken/
//   branch_target     : redirect to branch_target
//   jump/jump_target  : redirect to jump_target (wins over branch)
//   imem              : fetch_stage_if master (imem_addr / imem_rdata)
//   if_id_pc/instr/
//   if_id_opcode/valid: IF/ID pipeline register contents
//   stall_cnt         : stall-cycle counter
//   flush_cnt         : bubble-insertion counter
//
// Configuration macro: FETCH_PERF_CNT_EN
//   defined   -> stall_cnt / flush_cnt are saturating 32-bit counters
//   undefined -> both outputs are tied to 0 and no counter registers exist
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 enable,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 branch_taken,
  input  logic [63:0]          branch_target,
  input  logic                 jump,
  input  logic [63:0]          jump_target,
  fetch_stage_if.master        imem,
  output logic [63:0]          if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic [6:0]           if_id_opcode,
  output logic                 if_id_valid,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);

  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic        redirect;
  logic        bubble;

  assign redirect = jump | branch_taken;
  // A bubble goes into IF/ID for an explicit flush or for any redirect; the
  // instruction fetched this cycle is on the wrong path in the latter case.
  assign bubble   = flush | redirect;

  assign imem.imem_addr = pc_q;
  assign if_id_opcode   = if_id_instr[6:0];

  // Next PC: jump beats branch beats stall beats sequential. Redirect
  // targets are word aligned by clearing bits [1:0]; PC+4 wraps naturally.
  always_comb begin
    pc_d = pc_q + 64'd4;
    if (jump) begin
      pc_d = {jump_target[63:2], 2'b00};
    end else if (branch_taken) begin
      pc_d = {branch_target[63:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pc_q <= RESET_PC;
    end else if (enable) begin
      pc_q <= pc_d;
    end
  end

  // IF/ID register: bubble has priority over stall, so a redirect arriving
  // together with a stall drops the stall for that cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      if_id_pc    <= 64'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (enable) begin
      if (bubble) begin
        if_id_pc    <= pc_q;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if_id_pc    <= pc_q;
        if_id_instr <= imem.imem_rdata;
        if_id_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Stall cycles only count when the stall actually holds the pipe, i.e.
  // it was not overridden by a redirect. Both counters saturate.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else if (enable) begin
      if (stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bubble && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), meaning the bubble instruction.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port arst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: global core enable; low freezes all state.
REQ-006 The block SHALL have port stall, input, 1 bit: hazard-unit hold request.
REQ-007 The block SHALL have port flush, input, 1 bit: squash the IF/ID contents.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: redirect the PC to branch_target.
REQ-009 The block SHALL have port branch_target, input, 64 bits: branch destination address.
REQ-010 The block SHALL have port jump, input, 1 bit: redirect the PC to jump_target.
REQ-011 The block SHALL have port jump_target, input, 64 bits: jump destination address.
REQ-012 The block SHALL have port imem_addr, output, 64 bits: instruction memory address (combinational read).
REQ-013 The block SHALL have port imem_rdata, input, 32 bits: instruction word at imem_addr, valid in the same cycle.
REQ-014 The block SHALL have port if_id_pc, output, 64 bits: PC of the registered instruction.
REQ-015 The block SHALL have port if_id_instr, output, 32 bits: registered instruction.
REQ-016 The block SHALL have port if_id_opcode, output, 7 bits: if_id_instr[6:0]; this is the decoder opcode input.
REQ-017 The block SHALL have port if_id_valid, output, 1 bit: high when if_id_instr is a real fetched instruction.
REQ-018 The block SHALL have port stall_cnt, output, 32 bits: stall-cycle count.
REQ-019 The block SHALL have port flush_cnt, output, 32 bits: bubble-insertion count.

Function
REQ-020 imem_addr SHALL equal the PC register combinationally.
REQ-021 When enable is low, the PC, the IF/ID register and the counters SHALL hold their values regardless of the other inputs.
REQ-022 Next-PC priority with enable high SHALL be: jump -> jump_target; else branch_taken -> branch_target; else stall -> hold; else PC+4.
REQ-023 Redirect targets SHALL have bits [1:0] forced to 0.
REQ-024 PC+4 SHALL wrap modulo 2^64 (for example, 64'hFFFF_FFFF_FFFF_FFFC becomes 64'h0).
REQ-025 The IF/ID register SHALL load NOP_INSTR with valid=0 and pc=current PC when flush, jump or branch_taken is high; this takes priority over stall.
REQ-026 Otherwise, the IF/ID register SHALL hold when stall is high, else load {PC, imem_rdata} with valid=1.
REQ-027 Fetch latency SHALL be one cycle: the word addressed in cycle N appears on if_id_instr after edge N+1.
REQ-028 When redirect and stall occur simultaneously, the redirect SHALL win and the stall SHALL be dropped for that cycle.
REQ-029 A redirect SHALL cause exactly one bubble.

Reset
REQ-030 While arst is high, PC SHALL be RESET_PC.
REQ-031 While arst is high, if_id_instr SHALL be NOP_INSTR, if_id_pc SHALL be 0 and if_id_valid SHALL be 0.
REQ-032 While arst is high, stall_cnt and flush_cnt SHALL be 0.
REQ-033 Assertion of arst mid-operation SHALL take effect immediately, without a clock edge.
REQ-034 On the first edge after arst deasserts, the block SHALL fetch from RESET_PC.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN: when defined, stall_cnt SHALL increment on each cycle with enable & stall & no redirect, saturating at 32'hFFFFFFFF.
REQ-036 Macro FETCH_PERF_CNT_EN: when defined, flush_cnt SHALL increment on each cycle a bubble is loaded, saturating at 32'hFFFFFFFF.
REQ-037 When FETCH_PERF_CNT_EN is undefined, stall_cnt and flush_cnt SHALL remain present and be tied to 0, and no counter registers SHALL exist.

Verification
REQ-038 Scenario: release reset with RESET_PC=0 and memory holding 0x00500093 at address 0 -> after 1 edge, if_id_instr=0x00500093, if_id_pc=0, valid=1, if_id_opcode=7'b0010011.
REQ-039 Scenario: stall held for 3 cycles at PC=0x8 -> PC stays 0x8, the IF/ID register is unchanged, and stall_cnt=3 (macro on).
REQ-040 Scenario: branch_taken with branch_target=0x41 and stall=1 at the same time -> next PC=0x40, IF/ID=NOP with valid=0, flush_cnt+1, stall_cnt unchanged.
REQ-041 Scenario: jump and branch_taken both high, jump_target=0x100, branch_target=0x200 -> next PC=0x100.
REQ-042 Scenario: PC=64'hFFFF_FFFF_FFFF_FFFC with no stall -> next PC=0.
REQ-043 Scenario: assert arst between edges with PC=0x20 -> PC=RESET_PC and valid=0 immediately; enable=0 then freezes all outputs across 5 edges.
